prog_loader: RTL

Program loader and instruction memory for the 16-bit toy core. It receives a byte stream over a valid/ready handshake, packs the bytes into 16-bit instruction words and writes them into a 256-entry instruction memory. It serves the core's fetch port from that memory with a registered read, and holds the core in reset until a complete program has been loaded. It is the writer side of the memory that the core reads instruction words from: bits [15:12] are the register select, [11:8] the opcode, [7:0] the immediate.

---
 rtl/prog_loader.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
//
// Program loader and instruction memory for the 16-bit toy core. It takes a
// byte stream over a valid/ready handshake, packs byte pairs into 16-bit
// instruction words and writes them into the instruction memory. The core's
// fetch port reads that memory with one cycle of latency. The core is held in
// reset until a complete program has been loaded.
//
// Stream format: count byte N (0 means 256), then N words, each sent low byte
// first and high byte second. Optionally, a trailing XOR checksum byte follows.
//
// Word layout: [15:12] register select, [11:8] opcode, [7:0] immediate.
//
// Optional feature:
//   LOADER_CHECKSUM_EN - when defined, the stream carries a trailing XOR
//   checksum byte. A mismatch parks the loader in an error state with the
//   core held in reset. When undefined, err is constant 0.
//
// Ports:
//   clk           clock; all logic is on the rising edge
//   rst           synchronous active-high reset; aborts any load in progress
//   start         one-cycle pulse; restarts a load from DONE or ERR
//   in_valid      stream byte valid
//   in_data       stream byte
//   in_ready      loader accepts a byte this cycle
//   rd_addr       core fetch address
//   rd_data       word at rd_addr, registered (1-cycle latency)
//   core_rst      hold the core in reset (high unless DONE)
//   busy          load in progress
//   done          program loaded, core released
//   err           checksum mismatch
//   words_loaded  words written in the current load
// -----------------------------------------------------------------------------
module prog_loader #(
  parameter int DEPTH = 256  // address width is fixed at 8 bits
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic [7:0]  rd_addr,
  output logic [15:0] rd_data,
  output logic        core_rst,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [8:0]  words_loaded
);

  typedef enum logic [2:0] {
    S_CNT,
    S_LO,
    S_HI,
`ifdef LOADER_CHECKSUM_EN
    S_CSUM,
    S_ERR,
`endif
    S_DONE
  } state_t;

  // All status outputs are registered together with the state.
  typedef struct packed {
    logic ready;
    logic busy;
    logic core_rst;
    logic done;
    logic err;
  } flags_t;

  function automatic flags_t flags_of(input state_t s);
    flags_t f;
    f = '0;
    case (s)
      S_CNT, S_LO, S_HI: begin
        f.ready    = 1'b1;
        f.busy     = 1'b1;
        f.core_rst = 1'b1;
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        f.ready    = 1'b1;
        f.busy     = 1'b1;
        f.core_rst = 1'b1;
      end
      S_ERR: begin
        f.core_rst = 1'b1;
        f.err      = 1'b1;
      end
`endif
      S_DONE:  f.done     = 1'b1;
      default: f.core_rst = 1'b1;
    endcase
    return f;
  endfunction

  state_t      state;
  flags_t      flags;
  logic [7:0]  wr_ptr;
  logic [7:0]  lo_byte;
  logic [8:0]  target;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  logic [15:0] mem [DEPTH];

  logic accept;
  logic wr_en;

  assign accept = in_valid && flags.ready;
  assign wr_en  = accept && (state == S_HI);

  assign in_ready = flags.ready;
  assign busy     = flags.busy;
  assign core_rst = flags.core_rst;
  assign done     = flags.done;
  assign err      = flags.err;

  // Every transition updates state and the matching output flags together,
  // so the outputs change on the same edge as the state.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_CNT;
      flags        <= flags_of(S_CNT);
      wr_ptr       <= 8'd0;
      words_loaded <= 9'd0;
      lo_byte      <= 8'd0;
      target       <= 9'd0;
`ifdef LOADER_CHECKSUM_EN
      csum         <= 8'd0;
`endif
    end else begin
      case (state)
        S_CNT: if (accept) begin
          // A count byte of 0 encodes a full 256-word program.
          target       <= (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
          wr_ptr       <= 8'd0;
          words_loaded <= 9'd0;
`ifdef LOADER_CHECKSUM_EN
          csum         <= 8'd0;
`endif
          state        <= S_LO;
          flags        <= flags_of(S_LO);
        end

        S_LO: if (accept) begin
          lo_byte <= in_data;
`ifdef LOADER_CHECKSUM_EN
          csum    <= csum ^ in_data;
`endif
          state   <= S_HI;
          flags   <= flags_of(S_HI);
        end

        S_HI: if (accept) begin
          // wr_ptr wraps to 0 only after the 256th word, when the load ends.
          wr_ptr       <= wr_ptr + 8'd1;
          words_loaded <= words_loaded + 9'd1;
`ifdef LOADER_CHECKSUM_EN
          csum         <= csum ^ in_data;
`endif
          if (words_loaded + 9'd1 == target) begin
`ifdef LOADER_CHECKSUM_EN
            state <= S_CSUM;
            flags <= flags_of(S_CSUM);
`else
            state <= S_DONE;
            flags <= flags_of(S_DONE);
`endif
          end else begin
            state <= S_LO;
            flags <= flags_of(S_LO);
          end
        end

`ifdef LOADER_CHECKSUM_EN
        S_CSUM: if (accept) begin
          if (in_data == csum) begin
            state <= S_DONE;
            flags <= flags_of(S_DONE);
          end else begin
            state <= S_ERR;
            flags <= flags_of(S_ERR);
          end
        end

        S_ERR: if (start) begin
          state <= S_CNT;
          flags <= flags_of(S_CNT);
        end
`endif

        S_DONE: if (start) begin
          state <= S_CNT;
          flags <= flags_of(S_CNT);
        end

        default: begin
          state <= S_CNT;
          flags <= flags_of(S_CNT);
        end
      endcase
    end
  end

  // NOTE: the memory array has no reset; a program survives rst and start,
  // and only words actually written by a load change.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {in_data, lo_byte};
  end

  // A read in the same cycle as a write to that address returns the old word.
  always_ff @(posedge clk) begin
    if (rst) rd_data <= 16'd0;
    else     rd_data <= mem[rd_addr];
  end

endmodule
